// File: rtl/ppt_regfile_mc.sv
// Multi-channel PPT register map: per-channel shadow/active timing sets with
// atomic commit, coherent 16-bit done-count readback, sticky W1C done flags and IRQ.
module ppt_regfile_mc #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ADDR_W-1:0]      address,
  input  logic [7:0]             data_in,
  input  logic                   write_enable,
  input  logic                   read_enable,
  output logic [7:0]             data_out,
  output logic [5*NUM_CH-1:0]    clk_div,
  output logic [16*NUM_CH-1:0]   period,
  output logic [16*NUM_CH-1:0]   width,
  output logic [16*NUM_CH-1:0]   count,
  output logic [NUM_CH-1:0]      run_ppt,
  input  logic [16*NUM_CH-1:0]   count_done,
  input  logic [NUM_CH-1:0]      done,
  output logic                   irq
);

  localparam logic [4:0]  RST_CLK_DIV = 5'd9;
  localparam logic [15:0] RST_PERIOD  = 16'd128;
  localparam logic [15:0] RST_WIDTH   = 16'd1;
  localparam logic [15:0] RST_COUNT   = 16'd16;

  logic [4:0]  sh_clk_div  [NUM_CH];
  logic [15:0] sh_period   [NUM_CH];
  logic [15:0] sh_width    [NUM_CH];
  logic [15:0] sh_count    [NUM_CH];
  logic [4:0]  act_clk_div [NUM_CH];
  logic [15:0] act_period  [NUM_CH];
  logic [15:0] act_width   [NUM_CH];
  logic [15:0] act_count   [NUM_CH];
  logic [7:0]  cnt_hold    [NUM_CH];

  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] sticky;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_rise;
  logic [NUM_CH-1:0] sticky_clr;

  logic [7:0] cfg_sel [NUM_CH];
  logic [2:0] st_sel  [NUM_CH];
  logic [7:0] rd_data;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 8; k++)
        cfg_sel[c][k] = (address == ADDR_W'(8*c + k));
      for (int k = 0; k < 3; k++)
        st_sel[c][k] = (address == ADDR_W'(8*NUM_CH + 3*c + k));
    end
  end

  assign done_rise = done & ~done_q;

  always_comb begin
    sticky_clr = '0;
    for (int c = 0; c < NUM_CH; c++)
      sticky_clr[c] = write_enable & st_sel[c][2] & data_in[1];
  end

  // Read mux sees pre-write state, so a simultaneous write returns the old value.
  always_comb begin
    rd_data = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_sel[c][0]) rd_data = {3'b000, sh_clk_div[c]};
      if (cfg_sel[c][1]) rd_data = sh_period[c][7:0];
      if (cfg_sel[c][2]) rd_data = sh_period[c][15:8];
      if (cfg_sel[c][3]) rd_data = sh_width[c][7:0];
      if (cfg_sel[c][4]) rd_data = sh_width[c][15:8];
      if (cfg_sel[c][5]) rd_data = sh_count[c][7:0];
      if (cfg_sel[c][6]) rd_data = sh_count[c][15:8];
      if (cfg_sel[c][7]) rd_data = {5'b00000, irq_en[c], 1'b0, run_q[c]};
      if (st_sel[c][0])  rd_data = count_done[16*c +: 8];
      if (st_sel[c][1])  rd_data = cnt_hold[c];
      if (st_sel[c][2])  rd_data = {6'b000000, sticky[c], done[c]};
    end
  end

  always_comb begin
    clk_div = '0;
    period  = '0;
    width   = '0;
    count   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      clk_div[5*c +: 5]  = act_clk_div[c];
      period[16*c +: 16] = act_period[c];
      width[16*c +: 16]  = act_width[c];
      count[16*c +: 16]  = act_count[c];
    end
  end

  assign run_ppt = run_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sh_clk_div[c]  <= RST_CLK_DIV;
        sh_period[c]   <= RST_PERIOD;
        sh_width[c]    <= RST_WIDTH;
        sh_count[c]    <= RST_COUNT;
        act_clk_div[c] <= RST_CLK_DIV;
        act_period[c]  <= RST_PERIOD;
        act_width[c]   <= RST_WIDTH;
        act_count[c]   <= RST_COUNT;
        cnt_hold[c]    <= 8'h00;
      end
      run_q    <= '0;
      irq_en   <= '0;
      sticky   <= '0;
      done_q   <= '0;
      data_out <= 8'h00;
      irq      <= 1'b0;
    end else begin
      done_q <= done;
      for (int c = 0; c < NUM_CH; c++) begin
        if (write_enable) begin
          if (cfg_sel[c][0]) sh_clk_div[c]      <= data_in[4:0];
          if (cfg_sel[c][1]) sh_period[c][7:0]  <= data_in;
          if (cfg_sel[c][2]) sh_period[c][15:8] <= data_in;
          if (cfg_sel[c][3]) sh_width[c][7:0]   <= data_in;
          if (cfg_sel[c][4]) sh_width[c][15:8]  <= data_in;
          if (cfg_sel[c][5]) sh_count[c][7:0]   <= data_in;
          if (cfg_sel[c][6]) sh_count[c][15:8]  <= data_in;
          if (cfg_sel[c][7]) begin
            run_q[c]  <= data_in[0];
            irq_en[c] <= data_in[2];
            if (data_in[1]) begin
              act_clk_div[c] <= sh_clk_div[c];
              act_period[c]  <= sh_period[c];
              act_width[c]   <= sh_width[c];
              act_count[c]   <= sh_count[c];
            end
          end
        end
        // Latch the high byte with the low-byte read so the pair is coherent.
        if (read_enable && st_sel[c][0])
          cnt_hold[c] <= count_done[16*c+8 +: 8];
      end
      sticky <= done_rise | (sticky & ~sticky_clr);
      irq    <= |(sticky & irq_en);
      if (read_enable)
        data_out <= rd_data;
    end
  end

endmodule

// File: doc/ppt_regfile_mc.md
Name: ppt_regfile_mc

Overview:
Multi-channel, parametrised successor to the single-channel PPT register map. It sits between the I2C slave byte interface and NUM_CH PPT controllers. Each channel has a shadow/active register pair so a new timing set takes effect atomically on commit. Status registers provide a sticky write-1-to-clear DONE flag, a coherent 16-bit COUNT_DONE readback and a combined interrupt output.

Parameters:
NUM_CH, 2, number of PPT channels (1..4)
ADDR_W, 6, byte address width; must satisfy 2^ADDR_W >= 11*NUM_CH

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
address  input  ADDR_W  byte address from the I2C slave
data_in  input  8  write data
write_enable  input  1  single-cycle write strobe
read_enable  input  1  single-cycle read strobe
data_out  output  8  registered read data
clk_div  output  5*NUM_CH  active CLK_DIV per channel; channel c at [5c+4:5c]
period  output  16*NUM_CH  active PERIOD per channel
width  output  16*NUM_CH  active WIDTH per channel
count  output  16*NUM_CH  active COUNT per channel
run_ppt  output  NUM_CH  active RUN bit per channel
count_done  input  16*NUM_CH  live fired-pulse count per channel
done  input  NUM_CH  live done level per channel
irq  output  1  registered interrupt request

Behaviour:
- Config block for channel c at base 8c. Offsets: 0 CLK_DIV[4:0], 1 PERIOD_L, 2 PERIOD_H, 3 WIDTH_L, 4 WIDTH_H, 5 COUNT_L, 6 COUNT_H, 7 CTRL.
- CTRL bits: bit0 RUN, bit1 COMMIT (write-only, reads 0), bit2 IRQ_EN. Other bits read 0.
- Status block for channel c at base 8*NUM_CH + 3c. Offsets: 0 CNT_DONE_L, 1 CNT_DONE_H, 2 STAT. STAT bit0 is live done; bit1 is DONE_STICKY (W1C).
- Unmapped addresses read 0x00 and ignore writes. CNT_DONE_L/H and STAT bit0 ignore writes.
- Writes to offsets 0-6 update the shadow register only. Active outputs do not change.
- A write to CTRL updates RUN and IRQ_EN in the active set on that edge.
- If CTRL bit1=1, all seven shadow bytes are copied to the active set on the same edge. clk_div, period, width and count change together, visible the cycle after the write.
- Config reads return shadow values; CTRL reads return active RUN and IRQ_EN.
- Reset (async, rstn low) sets shadow and active to: CLK_DIV=9, PERIOD=128, WIDTH=1, COUNT=16, RUN=0, IRQ_EN=0. It also clears DONE_STICKY, the snapshot registers, data_out and irq.
- Reset mid-operation aborts any pending readback: data_out=0 the cycle after release.
- Read latency: data_out updates on the edge where read_enable=1 and holds otherwise. Value is valid the cycle after the strobe.
- Coherent count read:
  - A read of CNT_DONE_L returns count_done[c][7:0] and captures count_done[c][15:8] into a per-channel hold register on the same edge.
  - A read of CNT_DONE_H returns the hold register, not the live value.
- DONE_STICKY is set on a done[c] rising edge, detected against a registered copy of done. done is already synchronous to clk.
  - It is cleared by writing STAT with bit1=1.
  - If a set and a clear occur on the same edge, set wins.
- irq is registered: irq <= OR over c of (DONE_STICKY[c] & IRQ_EN[c]). It deasserts one cycle after the last contributing flag clears.
- If write_enable and read_enable are asserted together, the write occurs and data_out returns the pre-write value at that address.

Test Plan:
- Reset: release rstn -> period[15:0]=128, width=1, count=16, clk_div[4:0]=9, run_ppt=0, irq=0; read addr 0x01 -> 0x80.
- Shadow/commit: write ch1 PERIOD_L=0x34, PERIOD_H=0x12 (addr 0x09, 0x0A) -> period[31:16] stays 128. Write addr 0x0F=0x03 -> next cycle period[31:16]=0x1234 and run_ppt[1]=1.
- Coherent read: count_done ch0=0x01FF, read addr 0x10 (NUM_CH=2) -> 0xFF. Change count_done to 0x0200, then read 0x11 -> 0x01 (held byte), not 0x02.
- Sticky/IRQ:
  - Set IRQ_EN on ch0, then pulse done[0] for 1 cycle -> STAT (0x12) reads 0x02 and irq=1.
  - Write 0x02 to 0x12 -> irq=0 one cycle later.
  - Repeat with the clear coinciding with a new rising edge -> flag stays set.
- Unmapped/read-only: write 0xAA to addr 0x3F and to 0x10 -> reads return 0x00 and live count respectively; active outputs unchanged.
- Async reset mid-run: assert rstn low between strobe and data_out update after a commit -> all outputs return to reset defaults immediately, without waiting for clk.
